// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Consumes a byte stream (16-bit little-endian word count, then little-endian
// 32-bit instructions) and issues one word write per assembled instruction.
// The core is kept in reset until the whole program has been written.

module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] length_q, length_d;
  logic [1:0]  lane_q, lane_d;
  // Lanes 0..2 only; the fourth byte goes straight into mem_wr_data.
  logic [23:0] asm_q, asm_d;
  // Words fully assembled so far; runs one cycle ahead of words_loaded.
  logic [15:0] assembled_q, assembled_d;
  logic [15:0] words_q, words_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        xfer;
  logic        start_accept;
  logic        last_write;
  logic [15:0] len_full;

  assign xfer         = rx_valid && rx_ready;
  assign start_accept = start && (state_q == S_IDLE || state_q == S_DONE ||
                                  state_q == S_ERROR);
  assign len_full     = {rx_data, length_q[7:0]};
  assign last_write   = wr_en_q && ((words_q + 16'd1) == length_q);

  // State and datapath registers, asynchronously cleared.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      length_q    <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      assembled_q <= '0;
      words_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      assembled_q <= assembled_d;
      words_q     <= words_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state logic for the load sequence.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_accept) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)                   state_d = S_DONE;
          else if ({16'd0, len_full} > 32'(DEPTH)) state_d = S_ERROR;
          else                                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_write) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte-lane assembly, write strobe and counters.
  always_comb begin
    length_d    = length_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    assembled_d = assembled_q;
    words_d     = words_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (state_q == S_LEN_LO && xfer) length_d[7:0]  = rx_data;
    if (state_q == S_LEN_HI && xfer) length_d[15:8] = rx_data;

    if (state_q == S_DATA && xfer) begin
      unique case (lane_q)
        2'd0: asm_d[7:0]   = rx_data;
        2'd1: asm_d[15:8]  = rx_data;
        2'd2: asm_d[23:16] = rx_data;
        default: begin
          wr_en_d     = 1'b1;
          wr_data_d   = {rx_data, asm_q};
          wr_addr_d   = BASE_ADDR + {14'd0, assembled_q, 2'b00};
          assembled_d = assembled_q + 16'd1;
        end
      endcase
      lane_d = lane_q + 2'd1;
    end

    // The count advances at the end of the write cycle itself.
    if (wr_en_q) words_d = words_q + 16'd1;

    if (start_accept) begin
      lane_d      = 2'd0;
      assembled_d = 16'd0;
      words_d     = 16'd0;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DATA: begin
        rx_ready = (assembled_q != length_q);
        busy     = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the
// normal, zero-length and oversize loads, then hand-written sequences for
// backpressure, reset mid-load and a full-depth load at a non-zero base.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rdy_a, wen_a, hold_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic [15:0] words_a;
  logic        rdy_b, wen_b, hold_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, data_b;
  logic [15:0] words_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rdy_a), .mem_wr_en(wen_a),
    .mem_wr_addr(addr_a), .mem_wr_data(data_a), .core_hold(hold_a),
    .busy(busy_a), .done(done_a), .error(err_a), .words_loaded(words_a)
  );

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rdy_b), .mem_wr_en(wen_b),
    .mem_wr_addr(addr_b), .mem_wr_data(data_b), .core_hold(hold_b),
    .busy(busy_b), .done(done_b), .error(err_b), .words_loaded(words_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  // Write monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wen_a) qa.push_back('{addr_a, data_a});
    if (wen_b) qb.push_back('{addr_b, data_b});
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        e_rdy;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic        e_hold;
    logic [15:0] e_words;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic v, input logic [7:0] d,
                     input logic rdy, input logic wen, input logic [31:0] a,
                     input logic [31:0] dt, input logic bsy, input logic dn,
                     input logic er, input logic hd, input logic [15:0] w);
    vec_t t;
    t.start = st;  t.valid = v;    t.data = d;
    t.e_rdy = rdy; t.e_wen = wen;  t.e_addr = a; t.e_data = dt;
    t.e_busy = bsy; t.e_done = dn; t.e_err = er; t.e_hold = hd;
    t.e_words = w;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until accepted; reports stall cycles.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    int waits;
    waits    = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rdy_a && waits < 20) begin
      tick();
      waits++;
    end
    if (!rdy_a) check("rx_ready_timeout", 32'(rdy_a), 32'd1);
    tick();
    rx_valid = 1'b0;
    stalls   = waits;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(done_a), 32'd1);
  endtask

  function automatic logic [31:0] word_of(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
  endfunction

  logic [7:0]  prog[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50,
                             8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  wr_t         exp_prog[2];

  initial begin
    int   s;
    int   stall_total;
    logic [31:0] w;
    vec_t v;

    exp_prog[0] = '{32'h0000_0000, 32'h0050_0013};
    exp_prog[1] = '{32'h0000_0004, 32'h0010_0093};

    // Normal two-word load (state before: IDLE after reset).
    add(1, 0, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h02, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h13, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h50, 1, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 1, 32'h0, 32'h0050_0013, 1, 0, 0, 1, 0);
    add(0, 1, 8'h93, 1, 0, 32'h0, 32'h0050_0013, 1, 0, 0, 1, 1);
    add(0, 1, 8'h00, 1, 0, 32'h0, 32'h0050_0013, 1, 0, 0, 1, 1);
    add(0, 1, 8'h10, 1, 0, 32'h0, 32'h0050_0013, 1, 0, 0, 1, 1);
    add(0, 1, 8'h00, 0, 1, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 1);
    add(0, 1, 8'hAA, 0, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0, 2);
    add(0, 1, 8'hBB, 0, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0, 2);
    // Zero-length load.
    add(1, 0, 8'h00, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 0, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 32'h4, 32'h0010_0093, 0, 1, 0, 0, 0);
    // Oversize length 257, then recovery with a one-word load.
    add(1, 0, 8'h00, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h01, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h01, 0, 0, 32'h4, 32'h0010_0093, 0, 0, 1, 1, 0);
    add(0, 1, 8'h55, 0, 0, 32'h4, 32'h0010_0093, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h01, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h78, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h56, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h34, 1, 0, 32'h4, 32'h0010_0093, 1, 0, 0, 1, 0);
    add(0, 1, 8'h12, 0, 1, 32'h0, 32'h1234_5678, 1, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 32'h0, 32'h1234_5678, 0, 1, 0, 0, 1);

    // Reset state.
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check("rst_rdy",   32'(rdy_a),   32'd0);
    check("rst_wen",   32'(wen_a),   32'd0);
    check("rst_addr",  addr_a,       32'd0);
    check("rst_data",  data_a,       32'd0);
    check("rst_hold",  32'(hold_a),  32'd1);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    check("rst_err",   32'(err_a),   32'd0);
    check("rst_words", 32'(words_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Table-driven per-cycle vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      v        = vecs[i];
      start    = v.start;
      rx_valid = v.valid;
      rx_data  = v.data;
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
      check($sformatf("v%0d_rdy", i),   32'(rdy_a),   32'(v.e_rdy));
      check($sformatf("v%0d_wen", i),   32'(wen_a),   32'(v.e_wen));
      check($sformatf("v%0d_addr", i),  addr_a,       v.e_addr);
      check($sformatf("v%0d_data", i),  data_a,       v.e_data);
      check($sformatf("v%0d_busy", i),  32'(busy_a),  32'(v.e_busy));
      check($sformatf("v%0d_done", i),  32'(done_a),  32'(v.e_done));
      check($sformatf("v%0d_err", i),   32'(err_a),   32'(v.e_err));
      check($sformatf("v%0d_hold", i),  32'(hold_a),  32'(v.e_hold));
      check($sformatf("v%0d_words", i), 32'(words_a), 32'(v.e_words));
    end

    // Backpressure with random gaps; an extra start while busy is ignored.
    qa.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick();
      end
      if (i == 7) begin
        pulse_start();
        check("t4_busy_after_start",  32'(busy_a),  32'd1);
        check("t4_words_after_start", 32'(words_a), 32'd1);
        check("t4_rdy_after_start",   32'(rdy_a),   32'd1);
      end
      send_byte(prog[i], s);
    end
    wait_done("t4_done_timeout");
    check("t4_words", 32'(words_a), 32'd2);
    check("t4_hold",  32'(hold_a),  32'd0);
    check("t4_count", 32'(qa.size()), 32'd2);
    for (int i = 0; i < 2 && i < qa.size(); i++) begin
      check($sformatf("t4_addr%0d", i), qa[i].addr, exp_prog[i].addr);
      check($sformatf("t4_data%0d", i), qa[i].data, exp_prog[i].data);
    end

    // Reset in the middle of a load, while a write strobe is active.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(prog[i], s);
    check("t5_pre_wen", 32'(wen_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rdy",   32'(rdy_a),   32'd0);
    check("t5_wen",   32'(wen_a),   32'd0);
    check("t5_addr",  addr_a,       32'd0);
    check("t5_data",  data_a,       32'd0);
    check("t5_hold",  32'(hold_a),  32'd1);
    check("t5_busy",  32'(busy_a),  32'd0);
    check("t5_words", 32'(words_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    qa.delete();
    tick();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(prog[i], s);
    wait_done("t5_done_timeout");
    check("t5_count", 32'(qa.size()), 32'd2);
    for (int i = 0; i < 2 && i < qa.size(); i++) begin
      check($sformatf("t5_addr%0d", i), qa[i].addr, exp_prog[i].addr);
      check($sformatf("t5_data%0d", i), qa[i].data, exp_prog[i].data);
    end

    // Full-depth load, back-to-back bytes; dut_b has base 0x100.
    qa.delete();
    qb.delete();
    stall_total = 0;
    pulse_start();
    send_byte(8'h00, s);
    stall_total += s;
    send_byte(8'h01, s);
    stall_total += s;
    for (int i = 0; i < 256; i++) begin
      w = word_of(i);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], s);
        stall_total += s;
      end
    end
    wait_done("t6_done_timeout");
    check("t6_stalls",  32'(stall_total), 32'd0);
    check("t6_count_b", 32'(qb.size()), 32'd256);
    for (int i = 0; i < 256 && i < qb.size(); i++) begin
      check($sformatf("t6_addr%0d", i), qb[i].addr, 32'h100 + 32'(4 * i));
      check($sformatf("t6_data%0d", i), qb[i].data, word_of(i));
    end
    check("t6_count_a", 32'(qa.size()), 32'd256);
    if (qa.size() == 256) check("t6_last_addr_a", qa[255].addr, 32'h3FC);
    check("t6_words_b", 32'(words_b), 32'd256);
    check("t6_done_b",  32'(done_b),  32'd1);
    check("t6_busy_b",  32'(busy_b),  32'd0);
    check("t6_err_b",   32'(err_b),   32'd0);
    check("t6_hold_b",  32'(hold_b),  32'd0);
    check("t6_rdy_b",   32'(rdy_b),   32'd0);
    check("t6_words_a", 32'(words_a), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. The core's fetch path is the reader of that memory; this block is the writer that fills it.
- Accepts a byte stream (valid/ready) made of a 16-bit word-count header followed by little-endian 32-bit instructions.
- Issues one word write per assembled instruction.
- Holds the core in reset until the full program has been written.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words; a header count above this is an error.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts rx_data this cycle
- mem_wr_en  out  1  one-cycle instruction memory write strobe
- mem_wr_addr  out  32  byte address of the write, word-aligned
- mem_wr_data  out  32  instruction word to write
- core_hold  out  1  high keeps the core's reset asserted
- busy  out  1  load in progress
- done  out  1  last load completed successfully
- error  out  1  last load rejected
- words_loaded  out  16  words written in the current/last load

Behaviour:
- Reset (reset_n low, asynchronous, including mid-load):
  - state=IDLE.
  - rx_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0.
  - core_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Byte lane index=0, length register=0.
- Handshake: a byte is transferred only in a cycle where rx_valid && rx_ready at the clk edge. rx_data is ignored otherwise.
- IDLE:
  - rx_ready=0.
  - On start: go to LEN_LO. Set busy=1, done=0, error=0, words_loaded=0, core_hold=1, lane=0.
- LEN_LO: rx_ready=1. On transfer, length[7:0]=rx_data and go to LEN_HI.
- LEN_HI: rx_ready=1. On transfer, length[15:8]=rx_data, then evaluate the completed 16-bit length:
  - length==0: go to DONE.
  - length>DEPTH: go to ERROR.
  - otherwise: go to DATA.
- DATA:
  - rx_ready=1 until the final byte of the program is accepted, then 0.
  - Each transfer writes the byte into assembly lane `lane`: the first byte goes to bits 7:0, the fourth to bits 31:24. lane then increments mod 4.
  - On the 4th byte transfer (cycle N):
    - The assembled word (including that byte) is registered into mem_wr_data.
    - mem_wr_en=1 in cycle N+1 for exactly one cycle.
    - mem_wr_addr=BASE_ADDR + 4*words_loaded (value before increment).
    - words_loaded increments at the end of cycle N+1.
  - Byte acceptance continues during the write cycle with no bubble; the assembly register is separate from mem_wr_data.
  - After the write of word number `length`, go to DONE.
- DONE:
  - Entered the cycle after the final write (or after LEN_HI when length==0).
  - done=1, busy=0, core_hold=0 from that cycle.
  - Held until the next start, which re-enters LEN_LO with core_hold=1 and done=0.
- ERROR:
  - error=1, busy=0, core_hold stays 1, rx_ready=0.
  - No writes are issued. start restarts the load as from IDLE.
- start while busy=1 is ignored.
- rx_valid in IDLE/DONE/ERROR is ignored; rx_ready=0 in those states.
- mem_wr_addr and mem_wr_data hold their last values when mem_wr_en=0.
- Address arithmetic is 32-bit; the maximum write address is BASE_ADDR + 4*(DEPTH-1).

Test Plan:
1. Normal load:
   - Stimulus: reset; start; stream 02 00 13 00 50 00 93 00 10 00.
   - Required: writes 0x00500013 @0x0, then 0x00100093 @0x4, each one cycle after its 4th byte; then done=1, core_hold=0, words_loaded=2.
2. Zero-length load:
   - Stimulus: start, stream 00 00.
   - Required: DONE the cycle after the second byte; no mem_wr_en; core_hold=0; words_loaded=0.
3. Oversize length:
   - Stimulus: DEPTH=256, stream 01 01 (length 257).
   - Required: error=1, rx_ready=0, core_hold=1, no writes; a later start followed by a valid stream completes with done=1.
4. Backpressure and ignored start:
   - Stimulus: program from test 1 with random rx_valid gaps; start pulsed while busy.
   - Required: identical write sequence and addresses to test 1; the extra start has no effect.
5. Reset mid-load:
   - Stimulus: assert reset_n low after 6 bytes of test 1.
   - Required: all outputs take reset values immediately, without waiting for a clk edge (core_hold=1, words_loaded=0); a new start reloads from BASE_ADDR.
6. Base address and boundary:
   - Stimulus: BASE_ADDR=0x100, length=256 (00 01) with back-to-back bytes.
   - Required: 256 writes at 0x100..0x4FC with no byte stalls; done=1, words_loaded=256.
